// File: rtl/axis_maxpool_engine_if.sv
// AXI-Stream style bus carrying packed word beats plus sideband, with
// source (master) and sink (slave) views.
interface axis_maxpool_engine_if #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned USER_W = 4
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;

    modport master (output tvalid, output tdata, output tuser, output tlast, input  tready);
    modport slave  (input  tvalid, input  tdata, input  tuser, input  tlast, output tready);
endinterface

// File: rtl/axis_maxpool_engine.sv
// Optional 2x2 stride-2 signed max pooling of column beats; pooled columns are
// packed two per output beat, non-pooled packets pass through with 1-cycle latency.
module axis_maxpool_engine #(
    parameter int unsigned UNITS       = 8,
    parameter int unsigned GROUPS      = 2,
    parameter int unsigned COPIES      = 2,
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned TUSER_WIDTH = 4,
    parameter int unsigned I_IS_MAX    = 0
) (
    input  logic                   aclk,
    input  logic                   areset,
    axis_maxpool_engine_if.slave   s_axis,
    axis_maxpool_engine_if.master  m_axis
);
    localparam int unsigned NCG   = COPIES * GROUPS;
    localparam int unsigned HALF  = UNITS / 2;
    localparam int unsigned NWORD = NCG * UNITS;
    localparam int unsigned NCOL  = NCG * HALF;

    typedef enum logic [1:0] {ST_FIRST, ST_PASS, ST_POOL} state_t;

    state_t r_state;
    state_t w_state_next;
    logic [1:0] r_phase;

    logic [NCOL-1:0][WORD_WIDTH-1:0]  r_col;
    logic [NCOL-1:0][WORD_WIDTH-1:0]  r_pool_a;
    logic [NCOL-1:0][WORD_WIDTH-1:0]  w_vmax;
    logic [NCOL-1:0][WORD_WIDTH-1:0]  w_cur;
    logic [NWORD-1:0][WORD_WIDTH-1:0] w_in;
    logic [NWORD-1:0][WORD_WIDTH-1:0] w_out;
    logic [NWORD-1:0][WORD_WIDTH-1:0] r_data;
    logic [TUSER_WIDTH-1:0]           r_user;
    logic                             r_last;
    logic                             r_valid;

    logic w_pool_c;
    logic w_completing_c;
    logic w_ready_c;
    logic w_hs;

    assign w_in = s_axis.tdata;

    // Mode comes from the first beat's sideband while waiting for a packet start.
    assign w_pool_c       = (r_state == ST_FIRST) ? s_axis.tuser[I_IS_MAX] : (r_state == ST_POOL);
    assign w_completing_c = !w_pool_c || s_axis.tlast || (r_phase == 2'd3);
    assign w_ready_c      = !w_completing_c || !r_valid || m_axis.tready;
    assign w_hs           = s_axis.tvalid && w_ready_c;

    assign s_axis.tready = w_ready_c;
    assign m_axis.tvalid = r_valid;
    assign m_axis.tdata  = r_data;
    assign m_axis.tuser  = r_user;
    assign m_axis.tlast  = r_last;

    // Vertical pair max, combine with stored column on odd phases, assemble output.
    always_comb begin
        w_vmax = '0;
        w_cur  = '0;
        w_out  = '0;
        for (int unsigned cg = 0; cg < NCG; cg++) begin
            for (int unsigned k = 0; k < HALF; k++) begin
                w_vmax[cg*HALF+k] =
                    ($signed(w_in[cg*UNITS+2*k]) >= $signed(w_in[cg*UNITS+2*k+1]))
                    ? w_in[cg*UNITS+2*k] : w_in[cg*UNITS+2*k+1];
                w_cur[cg*HALF+k] =
                    (r_phase[0] && ($signed(r_col[cg*HALF+k]) > $signed(w_vmax[cg*HALF+k])))
                    ? r_col[cg*HALF+k] : w_vmax[cg*HALF+k];
                w_out[cg*UNITS+k]      = r_phase[1] ? r_pool_a[cg*HALF+k] : w_cur[cg*HALF+k];
                w_out[cg*UNITS+HALF+k] = r_phase[1] ? w_cur[cg*HALF+k] : '0;
            end
        end
        if (!w_pool_c) begin
            w_out = w_in;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_FIRST;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FIRST: begin
                if (w_hs && !s_axis.tlast) begin
                    w_state_next = w_pool_c ? ST_POOL : ST_PASS;
                end
            end
            ST_PASS, ST_POOL: begin
                if (w_hs && s_axis.tlast) begin
                    w_state_next = ST_FIRST;
                end
            end
            default: w_state_next = ST_FIRST;
        endcase
    end

    // Pool column storage and phase; phase wraps after 4 beats or at tlast.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_phase  <= 2'd0;
            r_col    <= '0;
            r_pool_a <= '0;
        end else if (w_hs && w_pool_c) begin
            if (!r_phase[0]) begin
                r_col <= w_vmax;
            end
            if (r_phase == 2'd1) begin
                r_pool_a <= w_cur;
            end
            r_phase <= (s_axis.tlast || r_phase == 2'd3) ? 2'd0 : r_phase + 2'd1;
        end
    end

    // Output register: load on completing handshake, else drain on tready.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_user  <= '0;
            r_last  <= 1'b0;
        end else if (w_hs && w_completing_c) begin
            r_valid <= 1'b1;
            r_data  <= w_out;
            r_user  <= s_axis.tuser;
            r_last  <= s_axis.tlast;
        end else if (m_axis.tready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_maxpool_engine.sv
// Directed bench for axis_maxpool_engine with UNITS=4, GROUPS=1, COPIES=1, 8-bit words.
module tb_axis_maxpool_engine;
    logic aclk = 1'b0;
    logic areset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [36:0] q_out[$];
    logic [36:0] got;

    axis_maxpool_engine_if #(.DATA_W(32), .USER_W(4)) s_if ();
    axis_maxpool_engine_if #(.DATA_W(32), .USER_W(4)) m_if ();

    axis_maxpool_engine #(
        .UNITS(4), .GROUPS(1), .COPIES(1), .WORD_WIDTH(8), .TUSER_WIDTH(4), .I_IS_MAX(0)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .s_axis (s_if.slave),
        .m_axis (m_if.master)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (!areset && m_if.tvalid && m_if.tready)
            q_out.push_back({m_if.tlast, m_if.tuser, m_if.tdata});
    end

    function automatic logic [31:0] pk(input int w0, input int w1, input int w2, input int w3);
        pk = {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
    endfunction

    task automatic send(input logic [31:0] d, input logic [3:0] u, input logic l, output int waits);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        waits = 0;
        @(negedge aclk);
        while (s_if.tready !== 1'b1 && waits < 50) begin
            waits++;
            @(negedge aclk);
        end
        if (waits >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout got=no_ready exp=ready");
        end
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        total++;
        if ({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata} !== 38'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata});
        end
        total++;
        if (s_if.tready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b exp=1", s_if.tready);
        end
        areset = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset_mid_pool();
        int w;
        m_if.tready = 1'b0;
        send(pk(1, 2, 3, 4), 4'h0, 1'b1, w);
        send(pk(7, 7, 7, 7), 4'h1, 1'b0, w);
        send(pk(6, 6, 6, 6), 4'h0, 1'b0, w);
        total++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== pk(1, 2, 3, 4)) begin
            bad++; $display("FAIL pre_reset_hold got=%h exp=%h", m_if.tdata, pk(1, 2, 3, 4));
        end
        areset = 1'b1;
        @(negedge aclk);
        total++;
        if ({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata} !== 38'd0) begin
            bad++; $display("FAIL midreset_outputs got=%h exp=0", {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata});
        end
        total++;
        if (s_if.tready !== 1'b1) begin
            bad++; $display("FAIL midreset_ready got=%b exp=1", s_if.tready);
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        m_if.tready = 1'b1;
        q_out.delete();
        send(pk(1, 5, -3, 2), 4'h1, 1'b0, w);
        send(pk(4, 0, -1, -7), 4'h0, 1'b0, w);
        drain();
        total++;
        if (q_out.size() != 0) begin
            bad++; $display("FAIL postreset_phase0 got=%0d exp=0 outputs", q_out.size());
        end
        send(pk(9, 9, 9, 9), 4'h0, 1'b0, w);
        send(pk(-8, -8, 10, -8), 4'h2, 1'b1, w);
        drain();
        total++;
        got = (q_out.size() > 0) ? q_out.pop_front() : 37'h0;
        if (got !== {1'b1, 4'h2, pk(5, 2, 9, 10)}) begin
            bad++; $display("FAIL postreset_pool got=%h exp=%h", got, {1'b1, 4'h2, pk(5, 2, 9, 10)});
        end
    endtask

    task automatic test_pass();
        int w;
        logic [31:0] d[3];
        d[0] = pk(1, -2, 3, -4);
        d[1] = pk(127, -128, 0, 5);
        d[2] = pk(-1, 66, 17, 9);
        m_if.tready = 1'b1;
        q_out.delete();
        for (int i = 0; i < 3; i++) begin
            send(d[i], 4'(2 * i), (i == 2), w);
            total++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== d[i]) begin
                bad++; $display("FAIL pass_latency%0d got=%h exp=%h", i, m_if.tdata, d[i]);
            end
        end
        drain();
        for (int i = 0; i < 3; i++) begin
            total++;
            got = (q_out.size() > 0) ? q_out.pop_front() : 37'h0;
            if (got !== {(i == 2), 4'(2 * i), d[i]}) begin
                bad++; $display("FAIL pass_beat%0d got=%h exp=%h", i, got, {(i == 2), 4'(2 * i), d[i]});
            end
        end
    endtask

    task automatic test_pool();
        int w;
        m_if.tready = 1'b1;
        q_out.delete();
        send(pk(1, 5, -3, 2), 4'h1, 1'b0, w);
        send(pk(4, 0, -1, -7), 4'h0, 1'b0, w);
        send(pk(9, 9, 9, 9), 4'h0, 1'b0, w);
        send(pk(-8, -8, 10, -8), 4'h2, 1'b1, w);
        drain();
        total++;
        if (q_out.size() != 1) begin
            bad++; $display("FAIL pool_count got=%0d exp=1", q_out.size());
        end
        total++;
        got = (q_out.size() > 0) ? q_out.pop_front() : 37'h0;
        if (got !== {1'b1, 4'h2, pk(5, 2, 9, 10)}) begin
            bad++; $display("FAIL pool_result got=%h exp=%h", got, {1'b1, 4'h2, pk(5, 2, 9, 10)});
        end
    endtask

    task automatic test_short_packet();
        int w;
        m_if.tready = 1'b1;
        q_out.delete();
        send(pk(-1, -2, -3, -4), 4'h1, 1'b0, w);
        send(pk(-5, -6, -7, -8), 4'h4, 1'b1, w);
        send(pk(1, 5, -3, 2), 4'h1, 1'b0, w);
        send(pk(4, 0, -1, -7), 4'h0, 1'b0, w);
        send(pk(9, 9, 9, 9), 4'h0, 1'b0, w);
        send(pk(-8, -8, 10, -8), 4'h8, 1'b1, w);
        drain();
        total++;
        got = (q_out.size() > 0) ? q_out.pop_front() : 37'h0;
        if (got !== {1'b1, 4'h4, pk(-1, -3, 0, 0)}) begin
            bad++; $display("FAIL short_result got=%h exp=%h", got, {1'b1, 4'h4, pk(-1, -3, 0, 0)});
        end
        total++;
        got = (q_out.size() > 0) ? q_out.pop_front() : 37'h0;
        if (got !== {1'b1, 4'h8, pk(5, 2, 9, 10)}) begin
            bad++; $display("FAIL short_next got=%h exp=%h", got, {1'b1, 4'h8, pk(5, 2, 9, 10)});
        end
    endtask

    task automatic test_backpressure();
        int w;
        logic [31:0] d[8];
        d[0] = pk(1, 5, -3, 2);     d[1] = pk(4, 0, -1, -7);
        d[2] = pk(9, 9, 9, 9);      d[3] = pk(-8, -8, 10, -8);
        d[4] = pk(-1, -2, -3, -4);  d[5] = pk(-5, -6, -7, -8);
        d[6] = pk(1, 5, -3, 2);     d[7] = pk(4, 0, -1, -7);
        m_if.tready = 1'b0;
        q_out.delete();
        for (int i = 0; i < 7; i++) begin
            send(d[i], 4'(2 * i + 1), 1'b0, w);
            if (i >= 4) begin
                total++;
                if (w != 0) begin
                    bad++; $display("FAIL bp_accept%0d got=%0d exp=0 waits", i, w);
                end
            end
        end
        s_if.tvalid = 1'b1;
        s_if.tdata  = d[7];
        s_if.tuser  = 4'd15;
        s_if.tlast  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            total++;
            if (s_if.tready !== 1'b0) begin
                bad++; $display("FAIL bp_stall%0d got=%b exp=0", i, s_if.tready);
            end
            total++;
            if ({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata} !== {2'b10, 4'd7, pk(5, 2, 9, 10)}) begin
                bad++; $display("FAIL bp_hold%0d got=%h exp=%h", i,
                    {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata}, {2'b10, 4'd7, pk(5, 2, 9, 10)});
            end
        end
        @(posedge aclk);
        #1;
        m_if.tready = 1'b1;
        send(d[7], 4'd15, 1'b1, w);
        drain();
        total++;
        got = (q_out.size() > 0) ? q_out.pop_front() : 37'h0;
        if (got !== {1'b0, 4'd7, pk(5, 2, 9, 10)}) begin
            bad++; $display("FAIL bp_out0 got=%h exp=%h", got, {1'b0, 4'd7, pk(5, 2, 9, 10)});
        end
        total++;
        got = (q_out.size() > 0) ? q_out.pop_front() : 37'h0;
        if (got !== {1'b1, 4'd15, pk(-1, -3, 5, 2)}) begin
            bad++; $display("FAIL bp_out1 got=%h exp=%h", got, {1'b1, 4'd15, pk(-1, -3, 5, 2)});
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int wsum;
        m_if.tready = 1'b1;
        q_out.delete();
        send(pk(10, -20, 30, -40), 4'h0, 1'b1, w);
        wsum = w;
        send(pk(1, 5, -3, 2), 4'h1, 1'b0, w);   wsum += w;
        send(pk(4, 0, -1, -7), 4'h0, 1'b0, w);  wsum += w;
        send(pk(9, 9, 9, 9), 4'h0, 1'b0, w);    wsum += w;
        send(pk(-8, -8, 10, -8), 4'h6, 1'b1, w); wsum += w;
        drain();
        total++;
        if (wsum != 0) begin
            bad++; $display("FAIL b2b_idle got=%0d exp=0 waits", wsum);
        end
        total++;
        got = (q_out.size() > 0) ? q_out.pop_front() : 37'h0;
        if (got !== {1'b1, 4'h0, pk(10, -20, 30, -40)}) begin
            bad++; $display("FAIL b2b_pass got=%h exp=%h", got, {1'b1, 4'h0, pk(10, -20, 30, -40)});
        end
        total++;
        got = (q_out.size() > 0) ? q_out.pop_front() : 37'h0;
        if (got !== {1'b1, 4'h6, pk(5, 2, 9, 10)}) begin
            bad++; $display("FAIL b2b_pool got=%h exp=%h", got, {1'b1, 4'h6, pk(5, 2, 9, 10)});
        end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        test_reset();
        test_pass();
        test_pool();
        test_short_packet();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_pool();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
